// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} e_fetch_state;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: imem request/response, redirect input and decode handshake.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] Instruction;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_pls4;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, Instruction, pc, pc_pls4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, Instruction, pc, pc_pls4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer: small synchronous FIFO with flush, count and empty/full flags.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flush wins over everything: a same-cycle push is discarded with the rest.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  always_comb begin
    rd_d  = do_pop  ? ptr_inc(rd_q) : rd_q;
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order imem requests, PC-tagged buffer toward decode,
// and redirect handling that drops responses still in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2,
  parameter int              CNT_W     = 2
) (
  input logic          clk,
  input logic          rstn,
  fetch_unit_if.master bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(BUF_DEPTH);

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d, drop_q, drop_d;

  logic [CNT_W-1:0] buf_cnt;
  logic             buf_empty, buf_full, push, pop, flush;
  fetch_entry_t     head, push_ent;
  logic             req_valid, accept, rsp_ok;
  logic [XLEN-1:0]  redir_pc, dec_pc;
  logic             unused_redir_lsbs;

  assign unused_redir_lsbs = ^bus.redirect_pc[1:0];
  assign redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

  // Requests in flight plus words already buffered may never exceed the buffer size,
  // so every response is guaranteed a slot.
  assign req_valid = (state_q != S_IDLE) && !bus.redirect_valid &&
                     (({1'b0, outst_q} + {1'b0, buf_cnt}) < CREDITS);
  assign accept    = req_valid && bus.imem_req_ready;
  assign rsp_ok    = bus.imem_rsp_valid && (outst_q != '0);
  assign pop       = !buf_empty && bus.dec_ready && !bus.redirect_valid;
  assign push_ent  = '{pc: rsp_pc_q, instr: bus.imem_rsp_data};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CNT_W'(accept) - CNT_W'(rsp_ok);
    push       = 1'b0;
    flush      = 1'b0;
    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      flush      = 1'b1;
      drop_d     = outst_q - CNT_W'(rsp_ok);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_ok) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else begin
          push     = 1'b1;
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
      end
    end
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (bus.redirect_valid && drop_d != '0) state_d = S_FLUSH;
      S_FLUSH: if (drop_d == '0) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_buf (
    .clk(clk), .rstn(rstn), .flush(flush), .push(push), .din(push_ent), .pop(pop),
    .dout(head), .count(buf_cnt), .empty(buf_empty), .full(buf_full)
  );

  assign dec_pc             = buf_empty ? '0 : head.pc;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.dec_valid      = !buf_empty;
  assign bus.Instruction    = buf_empty ? NOP_INSTR : head.instr;
  assign bus.pc             = dec_pc;
  assign bus.pc_pls4        = dec_pc + 32'd4;

  ap_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && buf_full && !pop));
  // Responses seen in IDLE are leftovers from before a reset and are ignored silently.
  ap_rsp_expected: assert property (@(posedge clk) disable iff (!rstn)
    (bus.imem_rsp_valid && state_q != S_IDLE) |-> (outst_q != '0));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a tagged-request memory/decode model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } mreq_t;

  mreq_t       mq[$];        // accepted requests awaiting a response, oldest first
  logic [31:0] orphan_q[$];  // requests cut off by a reset; memory still answers them
  logic [31:0] buf_q[$];     // PCs of words the decode stage should see, in order
  logic [31:0] exp_fpc;
  bit          started;
  int          cyc;
  int          p_rdy, p_rsp, p_dec, max_lat;
  bit          redir;
  logic [31:0] redir_tgt;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit          rsp_v, from_orphan, e_req, acc, popd;
    logic [31:0] rsp_d;
    mreq_t       m;
    rsp_v = 1'b0; from_orphan = 1'b0; rsp_d = 32'hDEAD_BEEF;
    if (orphan_q.size() > 0) begin
      rsp_v = 1'b1; from_orphan = 1'b1; rsp_d = orphan_q.pop_front() ^ KEY;
    end else if (rstn && mq.size() > 0 && mq[0].due <= cyc &&
                 int'($urandom_range(99)) < p_rsp) begin
      rsp_v = 1'b1; rsp_d = mq[0].addr ^ KEY;
    end
    bus.imem_rsp_valid = rsp_v;
    bus.imem_rsp_data  = rsp_d;
    bus.imem_req_ready = (int'($urandom_range(99)) < p_rdy);
    bus.dec_ready      = (int'($urandom_range(99)) < p_dec);
    bus.redirect_valid = redir;
    bus.redirect_pc    = redir_tgt;
    @(negedge clk);
    e_req = rstn && started && !redir && (mq.size() + buf_q.size() < 2);
    chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, e_req});
    if (e_req) chk("req_addr", bus.imem_req_addr, exp_fpc);
    chk("dec_valid", {31'b0, bus.dec_valid}, {31'b0, buf_q.size() > 0});
    if (buf_q.size() > 0) begin
      chk("dec_pc", bus.pc, buf_q[0]);
      chk("dec_instr", bus.Instruction, buf_q[0] ^ KEY);
      chk("dec_pc_pls4", bus.pc_pls4, buf_q[0] + 32'd4);
    end else begin
      chk("idle_instr", bus.Instruction, 32'h0000_0013);
      chk("idle_pc", bus.pc, 32'h0);
      chk("idle_pc_pls4", bus.pc_pls4, 32'h4);
    end
    if (rstn) begin
      acc  = e_req && bus.imem_req_ready;
      popd = buf_q.size() > 0 && bus.dec_ready && !redir;
      if (popd) void'(buf_q.pop_front());
      if (rsp_v && !from_orphan) begin
        m = mq.pop_front();
        if (!m.stale && !redir) buf_q.push_back(m.addr);
      end
      if (redir) begin
        buf_q.delete();
        foreach (mq[i]) mq[i].stale = 1'b1;
        exp_fpc = redir_tgt & 32'hFFFF_FFFC;
      end
      if (acc) begin
        mq.push_back('{addr: exp_fpc, stale: 1'b0, due: cyc + 1 + int'($urandom_range(max_lat))});
        exp_fpc = exp_fpc + 32'd4;
      end
      started = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic model_reset();
    foreach (mq[i]) orphan_q.push_back(mq[i].addr);
    mq.delete();
    buf_q.delete();
    exp_fpc = 32'h0;
    started = 1'b0;
  endtask

  // Drain the buffer and hold responses until two requests are in flight.
  task automatic get_two_outstanding(input string tag);
    int k;
    p_rdy = 100; p_dec = 100; p_rsp = 0; max_lat = 0;
    k = 0;
    while (!(mq.size() == 2 && buf_q.size() == 0) && k < 20) begin
      cycle();
      k++;
    end
    chk(tag, mq.size(), 2);
  endtask

  initial begin
    int k;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.dec_ready = 1'b0;
    p_rdy = 100; p_rsp = 100; p_dec = 100; max_lat = 0;
    redir = 1'b0; redir_tgt = '0; exp_fpc = '0; started = 1'b0; cyc = 0;

    // 1: reset, then first request in the second cycle after release
    run(2);
    rstn = 1'b1;
    run(4);

    // 2: streaming with everything ready
    run(20);

    // 3: decode stall, then release
    p_dec = 0;
    run(6);
    p_dec = 100;
    run(10);

    // 4: redirect with two requests outstanding
    get_two_outstanding("t4_setup");
    redir = 1'b1; redir_tgt = 32'h0000_0103;
    cycle();
    redir = 1'b0; p_rsp = 100;
    k = 0;
    while (!bus.dec_valid && k < 30) begin
      cycle();
      k++;
    end
    chk("t4_first_dec_pc", bus.pc, 32'h0000_0100);
    run(6);

    // 5: redirect coinciding with a response and a decode pop
    p_dec = 0; p_rsp = 100; max_lat = 0;
    k = 0;
    while (!(buf_q.size() == 1 && mq.size() == 1) && k < 20) begin
      cycle();
      k++;
    end
    chk("t5_setup", buf_q.size() + mq.size(), 2);
    p_dec = 100;
    redir = 1'b1; redir_tgt = 32'h0000_2000;
    cycle();
    redir = 1'b0;
    chk("t5_buf_empty", {31'b0, bus.dec_valid}, 32'h0);
    run(8);

    // 6: reset mid-stream with two outstanding; stale responses follow release
    get_two_outstanding("t6_setup");
    #1 rstn = 1'b0;
    #1;
    chk("t6_rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    chk("t6_rst_dec_valid", {31'b0, bus.dec_valid}, 32'h0);
    chk("t6_rst_instr", bus.Instruction, 32'h0000_0013);
    model_reset();
    p_rsp = 100;
    cycle();
    rstn = 1'b1;
    run(12);

    // 7: PC wrap at the top of the address space
    redir = 1'b1; redir_tgt = 32'hFFFF_FFFE;
    cycle();
    redir = 1'b0;
    run(10);

    // 8: randomized traffic with occasional redirects
    p_rdy = 70; p_rsp = 60; p_dec = 60; max_lat = 3;
    for (int i = 0; i < 400; i++) begin
      redir = ($urandom_range(99) < 4);
      redir_tgt = $urandom;
      cycle();
    end
    redir = 1'b0;
    p_rdy = 100; p_rsp = 100; p_dec = 100;
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
